// File: rtl/rriot_pkg.sv
// Shared types and constants for the RRIOT bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rriot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bus value that the 6530 decodes to nothing (CS1=0 with RS0=1).
  localparam logic       BUS_IDLE_WE_N = 1'b1;
  localparam logic [9:0] BUS_IDLE_A    = 10'h000;
  localparam logic [7:0] BUS_IDLE_DI   = 8'h00;
  localparam logic       BUS_IDLE_RS0  = 1'b1;
  localparam logic       BUS_IDLE_CS1  = 1'b0;

  // Read data returned when the 6530 does not drive OE.
  localparam logic [7:0] RD_MISS = 8'hFF;

  typedef struct packed {
    logic       we_n;
    logic       rs0;
    logic       cs1;
    logic [9:0] addr;
    logic [7:0] wdata;
  } req_t;

endpackage

// File: rtl/rriot_bus_arbiter_rr_pick.sv
// Round-robin winner select: first requester at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; gnt_oh is all-zero when no request is pending.
// Ports: req (request vector), ptr (start index), gnt_oh (one-hot winner),
//        gnt_idx (binary winner index, 0 when none).
module rr_pick #(
  parameter int NREQ = 2,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [PW-1:0]   gnt_idx
);

  logic found;
  int   j;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      // Rotate the scan so it starts at ptr; ptr is always < NREQ.
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        gnt_oh[j] = 1'b1;
        gnt_idx   = PW'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rriot_bus_arbiter.sv
// Round-robin arbiter sharing one mcs6530 bus port between NREQ requesters.
// Latency: write ack 3 cycles after req seen in IDLE, read ack 3+READ_LAT.
// Backpressure: requesters hold req until ack; one transaction in flight.
// Ports: phi2/rst_n; per-requester req, req_we_n, req_addr, req_sel {RS0,CS1},
//        req_wdata; gnt/ack/rdata/err back to requesters; bus_* to/from 6530.
module rriot_bus_arbiter
  import rriot_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int READ_LAT = 1
) (
  input  logic                phi2,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_we_n,
  input  logic [NREQ*10-1:0]  req_addr,
  input  logic [NREQ*2-1:0]   req_sel,
  input  logic [NREQ*8-1:0]   req_wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     ack,
  output logic [7:0]          rdata,
  output logic                err,
  output logic                bus_we_n,
  output logic [9:0]          bus_a,
  output logic [7:0]          bus_di,
  output logic                bus_rs0,
  output logic                bus_cs1,
  input  logic [7:0]          bus_do,
  input  logic                bus_oe
);

  localparam int PW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, owner, pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic            cur_we_n;
  logic [1:0]      cnt;
  logic            sample;
  logic            enter_done;
  req_t            pick_fields;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  // Gather the winning requester's fields from the flat input buses.
  always_comb begin
    pick_fields = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_fields.we_n  = req_we_n[i];
        pick_fields.rs0   = req_sel[2*i+1];
        pick_fields.cs1   = req_sel[2*i];
        pick_fields.addr  = req_addr[10*i +: 10];
        pick_fields.wdata = req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // sample marks the edge at which bus_do/bus_oe carry the read result.
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    case (state)
      IDLE: if (|req) state_nxt = ADDR;
      ADDR: begin
        if (!cur_we_n) begin
          state_nxt = DONE;
        end else if (READ_LAT == 0) begin
          sample    = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          sample    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_done = (state_nxt == DONE) && (state != DONE);

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      ack      <= '0;
      rdata    <= 8'h00;
      err      <= 1'b0;
      ptr      <= '0;
      owner    <= '0;
      cur_we_n <= 1'b1;
      cnt      <= 2'd0;
      bus_we_n <= BUS_IDLE_WE_N;
      bus_a    <= BUS_IDLE_A;
      bus_di   <= BUS_IDLE_DI;
      bus_rs0  <= BUS_IDLE_RS0;
      bus_cs1  <= BUS_IDLE_CS1;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= pick_idx;
            gnt      <= pick_oh;
            cur_we_n <= pick_fields.we_n;
            bus_we_n <= pick_fields.we_n;
            bus_a    <= pick_fields.addr;
            bus_di   <= pick_fields.wdata;
            bus_rs0  <= pick_fields.rs0;
            bus_cs1  <= pick_fields.cs1;
          end
        end
        ADDR: begin
          // Write strobe lasts exactly the ADDR cycle.
          bus_we_n <= 1'b1;
          if (state_nxt == WAIT) cnt <= 2'(READ_LAT - 1);
        end
        WAIT: if (cnt != 2'd0) cnt <= cnt - 2'd1;
        DONE: begin
          gnt <= '0;
          ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase

      if (enter_done) begin
        ack      <= gnt;
        bus_we_n <= BUS_IDLE_WE_N;
        bus_a    <= BUS_IDLE_A;
        bus_di   <= BUS_IDLE_DI;
        bus_rs0  <= BUS_IDLE_RS0;
        bus_cs1  <= BUS_IDLE_CS1;
        if (sample) begin
          rdata <= bus_oe ? bus_do : RD_MISS;
          err   <= !bus_oe;
        end else begin
          err   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rriot_bus_arbiter.sv
// Bench for rriot_bus_arbiter with a small 6530-like memory model on the bus.
// Latency: model returns DO/OE RD_LAT cycles after the address is driven.
// Backpressure: requests held until ack, then dropped unless marked held.
module tb_rriot_bus_arbiter;

  localparam int NREQ   = 2;
  localparam int RD_LAT = 1;
  localparam int RD_IDX = (RD_LAT == 0) ? 1 : RD_LAT;

  logic              phi2;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_we_n;
  logic [NREQ*10-1:0] req_addr;
  logic [NREQ*2-1:0] req_sel;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [7:0]        rdata;
  logic              err;
  logic              bus_we_n;
  logic [9:0]        bus_a;
  logic [7:0]        bus_di;
  logic              bus_rs0;
  logic              bus_cs1;
  logic [7:0]        bus_do;
  logic              bus_oe;

  rriot_bus_arbiter #(.NREQ(NREQ), .READ_LAT(RD_LAT)) dut (
    .phi2      (phi2),
    .rst_n     (rst_n),
    .req       (req),
    .req_we_n  (req_we_n),
    .req_addr  (req_addr),
    .req_sel   (req_sel),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .bus_we_n  (bus_we_n),
    .bus_a     (bus_a),
    .bus_di    (bus_di),
    .bus_rs0   (bus_rs0),
    .bus_cs1   (bus_cs1),
    .bus_do    (bus_do),
    .bus_oe    (bus_oe)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  // ---------------- 6530 stand-in: RAM mapped at 0x3C0..0x3FF, sel {1,0} ----
  logic [7:0] mem [0:1023] = '{default: 8'h00};
  logic [7:0] d0;
  logic       oe0;
  logic [7:0] pipe_d  [1:3];
  logic       pipe_oe [1:3];

  function automatic logic mapped(input logic [9:0] a, input logic rs0, input logic cs1);
    return (a[9:6] == 4'hF) && rs0 && !cs1;
  endfunction

  always_comb begin
    d0  = mem[bus_a];
    oe0 = mapped(bus_a, bus_rs0, bus_cs1) && bus_we_n;
  end

  always @(posedge phi2) begin
    if (!bus_we_n && mapped(bus_a, bus_rs0, bus_cs1)) mem[bus_a] <= bus_di;
    pipe_d[1]  <= d0;
    pipe_oe[1] <= oe0;
    for (int k = 2; k <= 3; k++) begin
      pipe_d[k]  <= pipe_d[k-1];
      pipe_oe[k] <= pipe_oe[k-1];
    end
  end

  assign bus_do = (RD_LAT == 0) ? d0  : pipe_d[RD_IDX];
  assign bus_oe = (RD_LAT == 0) ? oe0 : pipe_oe[RD_IDX];

  // ---------------- monitors ----------------
  int cyc = 0;
  int we_low = 0;
  int ack_cnt = 0;
  always @(posedge phi2) cyc <= cyc + 1;
  always @(negedge phi2) begin
    if (!bus_we_n) we_low <= we_low + 1;
    if (ack != '0) ack_cnt <= ack_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int         idx;
    logic [7:0] rd;
    logic       er;
    int         lat;
    int         t0;
  } exp_t;

  exp_t            sb[$];
  int              n_chk = 0;
  int              n_pass = 0;
  logic [NREQ-1:0] hold_mask = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_fields(input int i, input logic we_n, input logic [9:0] a,
                            input logic [1:0] sel, input logic [7:0] wd);
    req_we_n[i]         = we_n;
    req_addr[10*i +: 10] = a;
    req_sel[2*i +: 2]   = sel;
    req_wdata[8*i +: 8] = wd;
  endtask

  task automatic issue(input int i, input logic we_n, input logic [9:0] a,
                       input logic [1:0] sel, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input logic exp_er, input int lat);
    exp_t e;
    set_fields(i, we_n, a, sel, wd);
    req[i] = 1'b1;
    e.idx = i; e.rd = exp_rd; e.er = exp_er; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input string tag);
    exp_t            e;
    int              n;
    logic            seen_gnt;
    logic [NREQ-1:0] oh;
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 32'(ack), 32'hFFFF_FFFF);
      return;
    end
    e  = sb.pop_front();
    oh = '0;
    oh[e.idx] = 1'b1;
    n = 0;
    seen_gnt = 1'b0;
    while (ack == '0 && n < 30) begin
      @(posedge phi2); #1;
      n++;
      if (!seen_gnt && gnt != '0) begin
        seen_gnt = 1'b1;
        check({tag, " gnt"}, 32'(gnt), 32'(oh));
      end
    end
    check({tag, " ack"}, 32'(ack), 32'(oh));
    if (ack != '0) begin
      check({tag, " rdata"}, 32'(rdata), 32'(e.rd));
      check({tag, " err"}, 32'(err), 32'(e.er));
      if (e.lat >= 0) check({tag, " latency"}, 32'(cyc - e.t0 + 1), 32'(e.lat));
      if (!hold_mask[e.idx]) req[e.idx] = 1'b0;
      @(posedge phi2); #1;
      check({tag, " ack_once"}, 32'(ack), 32'(0));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge phi2);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acks0;
    int we0;
    rst_n     = 1'b0;
    req       = '0;
    req_we_n  = '1;
    req_addr  = '0;
    req_sel   = '0;
    req_wdata = '0;
    repeat (2) @(posedge phi2);
    #1;
    check("reset gnt", 32'(gnt), 32'(0));
    check("reset ack", 32'(ack), 32'(0));
    check("reset rdata", 32'(rdata), 32'(0));
    check("reset err", 32'(err), 32'(0));
    check("reset bus", 32'({bus_we_n, bus_a, bus_di, bus_rs0, bus_cs1}),
          32'({1'b1, 10'h000, 8'h00, 1'b1, 1'b0}));
    rst_n = 1'b1;
    @(posedge phi2); #1;

    // Write 0xA5 to 0x3C5 from requester 0; strobe must last one cycle.
    we0 = we_low;
    issue(0, 1'b0, 10'h3C5, 2'b10, 8'hA5, 8'h00, 1'b0, 3);
    @(posedge phi2); #1;
    check("wr0 bus addr", 32'({bus_we_n, bus_a, bus_di, bus_rs0, bus_cs1}),
          32'({1'b0, 10'h3C5, 8'hA5, 1'b1, 1'b0}));
    wait_ack("wr0");
    check("wr0 we_n pulse", 32'(we_low - we0), 32'(1));
    check("wr0 bus idle", 32'({bus_we_n, bus_a, bus_rs0, bus_cs1}),
          32'({1'b1, 10'h000, 1'b1, 1'b0}));

    // Read it back from requester 1.
    issue(1, 1'b1, 10'h3C5, 2'b10, 8'h00, 8'hA5, 1'b0, 3 + RD_LAT);
    wait_ack("rd1");

    // Both request from reset and keep requesting: 0,1,0,1.
    do_reset();
    hold_mask = '1;
    issue(0, 1'b1, 10'h3C5, 2'b10, 8'h00, 8'hA5, 1'b0, 3 + RD_LAT);
    issue(1, 1'b1, 10'h3C5, 2'b10, 8'h00, 8'hA5, 1'b0, -1);
    issue(0, 1'b1, 10'h3C5, 2'b10, 8'h00, 8'hA5, 1'b0, -1);
    issue(1, 1'b1, 10'h3C5, 2'b10, 8'h00, 8'hA5, 1'b0, -1);
    wait_ack("rr a");
    wait_ack("rr b");
    wait_ack("rr c");
    wait_ack("rr d");
    req       = '0;
    hold_mask = '0;
    repeat (2) @(posedge phi2);
    #1;

    // Unmapped read returns miss value with err.
    acks0 = ack_cnt;
    issue(0, 1'b1, 10'h000, 2'b10, 8'h00, 8'hFF, 1'b1, 3 + RD_LAT);
    wait_ack("miss");
    repeat (3) @(posedge phi2);
    #1;
    check("miss single ack", 32'(ack_cnt - acks0), 32'(1));

    // Requester 1 drops req and scribbles its fields during ADDR of a write.
    issue(1, 1'b0, 10'h3C6, 2'b10, 8'h5A, 8'hFF, 1'b0, 3);
    @(posedge phi2); #1;
    req[1] = 1'b0;
    set_fields(1, 1'b1, 10'h3C7, 2'b01, 8'h00);
    wait_ack("drop wr");
    issue(0, 1'b1, 10'h3C6, 2'b10, 8'h00, 8'h5A, 1'b0, 3 + RD_LAT);
    wait_ack("drop rb");

    // Reset asserted while a read sits in WAIT.
    acks0 = ack_cnt;
    issue(0, 1'b1, 10'h3C5, 2'b10, 8'h00, 8'hA5, 1'b0, -1);
    repeat (2) @(posedge phi2);
    #1;
    rst_n = 1'b0;
    void'(sb.pop_front());
    #1;
    check("rst gnt", 32'(gnt), 32'(0));
    check("rst bus", 32'({bus_we_n, bus_a, bus_di, bus_rs0, bus_cs1}),
          32'({1'b1, 10'h000, 8'h00, 1'b1, 1'b0}));
    repeat (3) @(posedge phi2);
    #1;
    check("rst no ack", 32'(ack_cnt - acks0), 32'(0));
    check("rst rdata", 32'(rdata), 32'(0));
    req   = '0;
    rst_n = 1'b1;
    repeat (2) @(posedge phi2);
    #1;
    check("sb drained", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
